// File: rtl/ysyx_25020047_wbu_pkg.sv
// Shared constants and FIFO entry type for the writeback stage.
// Optional misaligned-load checking: YSYX_25020047_WBU_MISALIGN_CHK_EN.
package ysyx_25020047_wbu_pkg;

  localparam logic [1:0] WB_SEL_NONE   = 2'd0;
  localparam logic [1:0] WB_SEL_RESULT = 2'd1;
  localparam logic [1:0] WB_SEL_LINK   = 2'd2;
  localparam logic [1:0] WB_SEL_LOAD   = 2'd3;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;

  // Entries are sized for the widest configuration; narrower builds use the low bits.
  localparam int unsigned WBU_XLEN_MAX    = 64;
  localparam int unsigned WBU_RF_ADDR_MAX = 5;

  typedef struct packed {
    logic [WBU_XLEN_MAX-1:0]    wdata;
    logic [WBU_XLEN_MAX-1:0]    dnpc;
    logic [WBU_RF_ADDR_MAX-1:0] rd;
    logic                       we;
`ifdef YSYX_25020047_WBU_MISALIGN_CHK_EN
    logic                       misalign;
`endif
  } wbu_entry_t;

  // Byte-offset bits that must be zero for an access of the given size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: return 3'b000;
      MEM_SIZE_H: return 3'b001;
      MEM_SIZE_W: return 3'b011;
      default:    return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25020047_load_fmt.sv
// Combinational load aligner: shifts the raw word by the byte offset, truncates to the
// access size and zero/sign-extends. Also flags offsets not aligned to the size.
module ysyx_25020047_load_fmt
  import ysyx_25020047_wbu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] memdata,
  input  logic [1:0]      size,
  input  logic            is_signed,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  localparam int unsigned OFF_W = (XLEN == 64) ? 3 : 2;

  localparam logic [XLEN-1:0] MASK_B = XLEN'(64'h0000_0000_0000_00ff);
  localparam logic [XLEN-1:0] MASK_H = XLEN'(64'h0000_0000_0000_ffff);
  localparam logic [XLEN-1:0] MASK_W = XLEN'(64'h0000_0000_ffff_ffff);

  logic [OFF_W-1:0] off;
  logic [1:0]       eff_size;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  mask;
  logic             sign_bit;

  assign off     = addr_lo[OFF_W-1:0];
  assign shifted = memdata >> {off, 3'b000};

  // A dword request on a 32-bit datapath degrades to a word load.
  always_comb begin
    eff_size = size;
    if ((size == MEM_SIZE_D) && (XLEN != 64)) begin
      eff_size = MEM_SIZE_W;
    end
  end

  always_comb begin
    mask     = '1;
    sign_bit = 1'b0;
    case (eff_size)
      MEM_SIZE_B: begin
        mask     = MASK_B;
        sign_bit = shifted[7];
      end
      MEM_SIZE_H: begin
        mask     = MASK_H;
        sign_bit = shifted[15];
      end
      MEM_SIZE_W: begin
        mask     = MASK_W;
        sign_bit = shifted[31];
      end
      default: begin
        mask     = '1;
        sign_bit = 1'b0;
      end
    endcase
    data = shifted & mask;
    if (is_signed && sign_bit) begin
      data = data | ~mask;
    end
  end

  assign misalign = |(addr_lo & align_mask(eff_size));

endmodule

// File: rtl/ysyx_25020047_wbu_pipe.sv
// Buffered writeback stage: formats retiring results into a DEPTH-entry FIFO, commits the
// head to the register file and PC, and counts retirements.
// Optional misaligned-load checking: YSYX_25020047_WBU_MISALIGN_CHK_EN.
module ysyx_25020047_wbu_pipe
  import ysyx_25020047_wbu_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     RF_ADDR_W = 5,
  parameter int unsigned     DEPTH     = 2,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000),
  parameter int unsigned     CNT_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_wb_sel,
  input  logic [RF_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]      in_result,
  input  logic [XLEN-1:0]      in_memdata,
  input  logic [1:0]           in_mem_size,
  input  logic                 in_mem_signed,
  input  logic [2:0]           in_addr_lo,
  input  logic [XLEN-1:0]      in_snpc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [XLEN-1:0]      dnpc,
  output logic [CNT_W-1:0]     retire_cnt
`ifdef YSYX_25020047_WBU_MISALIGN_CHK_EN
  , output logic               misalign_err
`endif
);

  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  wbu_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0]  count_q;
  logic [XLEN-1:0]      dnpc_q;
  logic [CNT_W-1:0]     retire_q;

  wbu_entry_t           new_entry;
  wbu_entry_t           head;
  logic [XLEN-1:0]      load_data;
  logic                 load_misalign;
  logic [XLEN-1:0]      wdata;
  logic                 push, pop;

  ysyx_25020047_load_fmt #(
    .XLEN(XLEN)
  ) u_load_fmt (
    .memdata  (in_memdata),
    .size     (in_mem_size),
    .is_signed(in_mem_signed),
    .addr_lo  (in_addr_lo),
    .data     (load_data),
    .misalign (load_misalign)
  );

  always_comb begin
    case (in_wb_sel)
      WB_SEL_RESULT: wdata = in_result;
      WB_SEL_LINK:   wdata = in_snpc;
      WB_SEL_LOAD:   wdata = load_data;
      default:       wdata = '0;
    endcase
  end

  always_comb begin
    new_entry       = '0;
    new_entry.wdata = WBU_XLEN_MAX'(wdata);
    new_entry.dnpc  = WBU_XLEN_MAX'((in_wb_sel == WB_SEL_LINK) ? in_result : in_snpc);
    new_entry.rd    = WBU_RF_ADDR_MAX'(in_rd);
    new_entry.we    = (in_wb_sel != WB_SEL_NONE) && (in_rd != '0);
`ifdef YSYX_25020047_WBU_MISALIGN_CHK_EN
    new_entry.misalign = (in_wb_sel == WB_SEL_LOAD) && load_misalign;
    if (new_entry.misalign) begin
      new_entry.we = 1'b0;
    end
`endif
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CNT_BITS'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dnpc_q   <= RESET_PC;
      retire_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= new_entry;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        dnpc_q   <= head.dnpc[XLEN-1:0];
        retire_q <= retire_q + CNT_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_BITS'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_BITS'(1);
      end
    end
  end

  assign rf_we      = pop && head.we;
  assign rf_waddr   = head.rd[RF_ADDR_W-1:0];
  assign rf_wdata   = head.wdata[XLEN-1:0];
  assign dnpc       = dnpc_q;
  assign retire_cnt = retire_q;

  // High entry bits are only meaningful in wider configurations.
  logic unused_head;
  assign unused_head = ^{head.wdata, head.dnpc, head.rd};

`ifdef YSYX_25020047_WBU_MISALIGN_CHK_EN
  assign misalign_err = pop && head.misalign;
`else
  logic unused_misalign;
  assign unused_misalign = load_misalign;
`endif

endmodule

// File: tb/tb_ysyx_25020047_wbu_pipe.sv
// Directed, table-driven bench for the writeback stage at its default parameters.
module tb_ysyx_25020047_wbu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wb_sel;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic [31:0] in_memdata;
  logic [1:0]  in_mem_size;
  logic        in_mem_signed;
  logic [2:0]  in_addr_lo;
  logic [31:0] in_snpc;
  logic        out_valid;
  logic        out_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] dnpc;
  logic [63:0] retire_cnt;
`ifdef YSYX_25020047_WBU_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  ysyx_25020047_wbu_pipe u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wb_sel    (in_wb_sel),
    .in_rd        (in_rd),
    .in_result    (in_result),
    .in_memdata   (in_memdata),
    .in_mem_size  (in_mem_size),
    .in_mem_signed(in_mem_signed),
    .in_addr_lo   (in_addr_lo),
    .in_snpc      (in_snpc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .dnpc         (dnpc),
    .retire_cnt   (retire_cnt)
`ifdef YSYX_25020047_WBU_MISALIGN_CHK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] memdata;
    logic [1:0]  size;
    logic        sgn;
    logic [2:0]  off;
    logic [31:0] snpc;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_dnpc;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_wb_sel     = v.sel;
    in_rd         = v.rd;
    in_result     = v.result;
    in_memdata    = v.memdata;
    in_mem_size   = v.size;
    in_mem_signed = v.sgn;
    in_addr_lo    = v.off;
    in_snpc       = v.snpc;
  endtask

  // Push one instruction with out_ready high, check the commit and the retired state.
  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    chk($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d rf_we", idx), 64'(rf_we), 64'(v.exp_we));
    chk($sformatf("v%0d rf_waddr", idx), 64'(rf_waddr), 64'(v.rd));
    chk($sformatf("v%0d rf_wdata", idx), 64'(rf_wdata), 64'(v.exp_wdata));
    @(negedge clk);
    exp_cnt++;
    chk($sformatf("v%0d dnpc", idx), 64'(dnpc), 64'(v.exp_dnpc));
    chk($sformatf("v%0d retire_cnt", idx), retire_cnt, exp_cnt);
    chk($sformatf("v%0d drained", idx), 64'(out_valid), 64'd0);
  endtask

  vec_t va, vb, vc;

  initial begin
    //          sel    rd     result        memdata       sz    sg    off   snpc         we    wdata         dnpc
    vecs[0]  = '{2'd1, 5'd5,  32'h0000_1234, 32'h0,        2'd2, 1'b0, 3'd0, 32'h8000_0004, 1'b1, 32'h0000_1234, 32'h8000_0004};
    vecs[1]  = '{2'd2, 5'd1,  32'h8000_0100, 32'h0,        2'd2, 1'b0, 3'd0, 32'h8000_0008, 1'b1, 32'h8000_0008, 32'h8000_0100};
    vecs[2]  = '{2'd3, 5'd10, 32'h0,        32'hFF80_7F01, 2'd0, 1'b1, 3'd1, 32'h8000_0104, 1'b1, 32'h0000_007F, 32'h8000_0104};
    vecs[3]  = '{2'd3, 5'd11, 32'h0,        32'hFF80_7F01, 2'd0, 1'b1, 3'd2, 32'h8000_0108, 1'b1, 32'hFFFF_FF80, 32'h8000_0108};
    vecs[4]  = '{2'd3, 5'd12, 32'h0,        32'hFF80_7F01, 2'd0, 1'b0, 3'd3, 32'h8000_010C, 1'b1, 32'h0000_00FF, 32'h8000_010C};
    vecs[5]  = '{2'd3, 5'd13, 32'h0,        32'hFF80_7F01, 2'd1, 1'b1, 3'd2, 32'h8000_0110, 1'b1, 32'hFFFF_FF80, 32'h8000_0110};
    vecs[6]  = '{2'd3, 5'd14, 32'h0,        32'hFF80_7F01, 2'd1, 1'b0, 3'd2, 32'h8000_0114, 1'b1, 32'h0000_FF80, 32'h8000_0114};
    vecs[7]  = '{2'd3, 5'd15, 32'h0,        32'hFF80_7F01, 2'd2, 1'b1, 3'd0, 32'h8000_0118, 1'b1, 32'hFF80_7F01, 32'h8000_0118};
    vecs[8]  = '{2'd0, 5'd7,  32'h0000_DEAD, 32'h0,        2'd2, 1'b0, 3'd0, 32'h8000_011C, 1'b0, 32'h0,         32'h8000_011C};
    vecs[9]  = '{2'd1, 5'd0,  32'h0000_0077, 32'h0,        2'd2, 1'b0, 3'd0, 32'h8000_0120, 1'b0, 32'h0000_0077, 32'h8000_0120};
    vecs[10] = '{2'd3, 5'd16, 32'h0,        32'hFF80_7F01, 2'd1, 1'b1, 3'd1, 32'h8000_0124, 1'b1, 32'hFFFF_807F, 32'h8000_0124};
    vecs[11] = '{2'd3, 5'd17, 32'h0,        32'hFF80_7F01, 2'd3, 1'b0, 3'd0, 32'h8000_0128, 1'b1, 32'hFF80_7F01, 32'h8000_0128};
    vecs[12] = '{2'd2, 5'd0,  32'h8000_0200, 32'h0,        2'd2, 1'b0, 3'd0, 32'h8000_012C, 1'b0, 32'h8000_012C, 32'h8000_0200};
    vecs[13] = '{2'd3, 5'd18, 32'h0,        32'hFF80_7F01, 2'd0, 1'b0, 3'd0, 32'h8000_0204, 1'b1, 32'h0000_0001, 32'h8000_0204};
`ifdef YSYX_25020047_WBU_MISALIGN_CHK_EN
    vecs[10].exp_we = 1'b0;
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(vecs[0]);
    repeat (2) @(negedge clk);
    chk("rst dnpc", 64'(dnpc), 64'h8000_0000);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst rf_we", 64'(rf_we), 64'd0);
    chk("rst rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst rf_wdata", 64'(rf_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle in_ready", 64'(in_ready), 64'd1);
    chk("idle retire_cnt", retire_cnt, 64'd0);
    chk("idle dnpc", 64'(dnpc), 64'h8000_0000);

    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      apply_vec(vecs[i], i);
    end

    // Backpressure: fill the FIFO, hold a third push, then drain in order.
    va = '{2'd1, 5'd21, 32'hA, 32'h0, 2'd2, 1'b0, 3'd0, 32'h100, 1'b1, 32'hA, 32'h100};
    vb = '{2'd1, 5'd22, 32'hB, 32'h0, 2'd2, 1'b0, 3'd0, 32'h104, 1'b1, 32'hB, 32'h104};
    vc = '{2'd1, 5'd23, 32'hC, 32'h0, 2'd2, 1'b0, 3'd0, 32'h108, 1'b1, 32'hC, 32'h108};
    @(negedge clk);
    out_ready = 1'b0;
    drive(va);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp ready after 1", 64'(in_ready), 64'd1);
    drive(vb);
    @(negedge clk);
    chk("bp ready after 2", 64'(in_ready), 64'd0);
    chk("bp out_valid", 64'(out_valid), 64'd1);
    chk("bp rf_we held", 64'(rf_we), 64'd0);
    chk("bp head A", 64'(rf_waddr), 64'd21);
    drive(vc);
    @(negedge clk);
    chk("bp still full", 64'(in_ready), 64'd0);
    chk("bp no retire", retire_cnt, exp_cnt);
    out_ready = 1'b1;
    #1;
    chk("bp no passthru", 64'(in_ready), 64'd0);
    chk("bp commit A we", 64'(rf_we), 64'd1);
    @(negedge clk);
    chk("bp C accepted late", 64'(in_ready), 64'd1);
    chk("bp head B", 64'(rf_waddr), 64'd22);
    chk("bp dnpc A", 64'(dnpc), 64'h100);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp head C", 64'(rf_waddr), 64'd23);
    chk("bp wdata C", 64'(rf_wdata), 64'hC);
    chk("bp dnpc B", 64'(dnpc), 64'h104);
    @(negedge clk);
    exp_cnt += 3;
    chk("bp drained", 64'(out_valid), 64'd0);
    chk("bp dnpc C", 64'(dnpc), 64'h108);
    chk("bp retire_cnt", retire_cnt, exp_cnt);

    // Reset with two entries queued discards them immediately.
    out_ready = 1'b0;
    drive(va);
    in_valid = 1'b1;
    @(negedge clk);
    drive(vb);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid-rst queued", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", 64'(out_valid), 64'd0);
    chk("mid-rst retire_cnt", retire_cnt, 64'd0);
    chk("mid-rst dnpc", 64'(dnpc), 64'h8000_0000);
    chk("mid-rst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = '0;
    out_ready = 1'b1;
    apply_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary within the time limit");
    $fatal(1);
  end

endmodule
